// File: rtl/seven_segment_display.sv
// Purpose: scans a double-buffered 16-bit hex value onto a multiplexed 4-digit 7-segment display.
// Latency: segment/digit outputs are registered, 1 clock after idx/shown/blank_lz; new values appear at the next frame start.
// Backpressure: none; value_valid is always accepted and the last strobe before a frame boundary wins.
module seven_segment_display #(
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        value_valid,
  input  logic [15:0] value,
  input  logic [3:0]  dots,
  input  logic        blank_lz,
  output logic [7:0]  abcdefgh,
  output logic [3:0]  digit
);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic             tick;
  logic             frame_end;

  logic [15:0]      pend_value;
  logic [3:0]       pend_dots;
  logic [15:0]      shown_value;
  logic [3:0]       shown_dots;

  logic [3:0]       cur_nib;
  logic             cur_dot;
  logic             cur_blank;
  logic [6:0]       font_seg;
  logic [7:0]       seg_nxt;
  logic [3:0]       digit_nxt;

  // Hex font, active-high segments ordered a..g.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

  assign tick      = &div_cnt;
  // The last tick of digit 3 is the frame boundary where the shown buffer swaps.
  assign frame_end = tick && (idx == 2'd3);

  // Refresh divider and digit index: one digit slot every 2^DIV_W clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      if (tick) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Pending buffer: every strobe is accepted, later ones overwrite uncommitted data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_value <= 16'h0000;
      pend_dots  <= 4'h0;
    end else if (value_valid) begin
      pend_value <= value;
      pend_dots  <= dots;
    end
  end

  // Shown buffer: takes pending's pre-edge contents only at frame boundaries, so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shown_value <= 16'h0000;
      shown_dots  <= 4'h0;
    end else if (frame_end) begin
      shown_value <= pend_value;
      shown_dots  <= pend_dots;
    end
  end

  // Select the current digit's nibble, dot and leading-zero blanking state.
  always_comb begin
    cur_nib   = shown_value[{idx, 2'b00} +: 4];
    cur_dot   = shown_dots[idx];
    cur_blank = 1'b0;
    case (idx)
      2'd1:    cur_blank = blank_lz && (shown_value[15:4]  == 12'h000);
      2'd2:    cur_blank = blank_lz && (shown_value[15:8]  == 8'h00);
      2'd3:    cur_blank = blank_lz && (shown_value[15:12] == 4'h0);
      default: cur_blank = 1'b0;
    endcase
    font_seg = hex_font(cur_nib);
    // A blanked digit keeps its decimal point and its enable so scan timing stays uniform.
    seg_nxt   = {(cur_blank ? 7'h7F : ~font_seg), ~cur_dot};
    digit_nxt = ~(4'b0001 << idx);
  end

  // Output registers: display stays fully dark while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abcdefgh <= 8'hFF;
      digit    <= 4'hF;
    end else begin
      abcdefgh <= seg_nxt;
      digit    <= digit_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_display.sv
// Purpose: self-checking bench for seven_segment_display with DIV_W=2 (16-clock frames).
// Latency: expected scan outputs are queued per driven cycle and popped 1 clock later.
// Backpressure: none; strobes are driven at fixed frame phases.
module tb_seven_segment_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        value_valid;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        blank_lz;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
  } obs_t;

  // segs = {digit3, digit2, digit1, digit0} expected abcdefgh bytes
  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dts;
    logic        blz;
    logic [31:0] segs;
  } vec_t;

  obs_t       exp_q[$];
  logic [7:0] cur_frame [4];
  vec_t       vecs [7];

  seven_segment_display #(.DIV_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_valid (value_valid),
    .value       (value),
    .dots        (dots),
    .blank_lz    (blank_lz),
    .abcdefgh    (abcdefgh),
    .digit       (digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got digit/seg %h, expected %h", name, act, req);
    end
  endtask

  task automatic set_frame(input logic [31:0] segs);
    for (int k = 0; k < 4; k++) cur_frame[k] = segs[8*k +: 8];
  endtask

  // Each cycle: push the expected output for the coming edge, clock, then pop and compare.
  task automatic run(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      int k;
      k = (ecnt / 4) % 4;
      exp_q.push_back({~(4'b0001 << k), cur_frame[k]});
      @(posedge clk);
      #1;
      ecnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: queue empty at edge %0d", ecnt);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("scan_edge%0d", ecnt), {digit, abcdefgh}, e);
      end
    end
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < 16 && (ecnt % 16) != phase; i++) run(1);
  endtask

  task automatic strobe(input logic [15:0] v, input logic [3:0] d);
    value       = v;
    dots        = d;
    value_valid = 1'b1;
    run(1);
    value_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{val: 16'h12AF, dts: 4'b0001, blz: 1'b0, segs: 32'h9F251170};
    vecs[1] = '{val: 16'h0007, dts: 4'b0000, blz: 1'b1, segs: 32'hFFFFFF1F};
    vecs[2] = '{val: 16'h0007, dts: 4'b0100, blz: 1'b1, segs: 32'hFFFEFF1F};
    vecs[3] = '{val: 16'h0000, dts: 4'b0000, blz: 1'b1, segs: 32'hFFFFFF03};
    vecs[4] = '{val: 16'h0900, dts: 4'b0000, blz: 1'b1, segs: 32'hFF090303};
    vecs[5] = '{val: 16'h8888, dts: 4'b1111, blz: 1'b0, segs: 32'h00000000};
    vecs[6] = '{val: 16'hCDE0, dts: 4'b0000, blz: 1'b0, segs: 32'h63856103};

    reset = 1'b1; value_valid = 1'b0; value = 16'h0; dots = 4'h0; blank_lz = 1'b0;
    #1;
    check("reset_initial", {digit, abcdefgh}, 12'hFFF);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {digit, abcdefgh}, 12'hFFF);
    @(negedge clk);
    reset = 1'b0;
    ecnt  = 0;

    // Two idle frames showing zero on every digit.
    set_frame(32'h03030303);
    run(32);

    // Table: strobe mid-frame, old frame must finish unchanged, new frame follows.
    for (int i = 0; i < 7; i++) begin
      run_to(5);
      strobe(vecs[i].val, vecs[i].dts);
      run_to(0);
      blank_lz = vecs[i].blz;
      set_frame(vecs[i].segs);
      run(16);
    end

    // Two strobes within one frame: last write wins.
    run_to(3);
    strobe(16'h1111, 4'h0);
    run_to(8);
    strobe(16'h2222, 4'h0);
    run_to(0);
    set_frame(32'h25252525);
    run(16);

    // Strobe on the commit edge lands a frame late.
    run_to(4);
    strobe(16'h3333, 4'h0);
    run_to(15);
    strobe(16'h4444, 4'h0);
    set_frame(32'h0D0D0D0D);
    run(16);
    set_frame(32'h99999999);
    run(16);

    // Asynchronous reset during idx=2 with a pending value.
    run_to(2);
    strobe(16'h5555, 4'hF);
    run_to(9);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_mid", {digit, abcdefgh}, 12'hFFF);
    @(negedge clk);
    check("reset_mid_held", {digit, abcdefgh}, 12'hFFF);
    @(negedge clk);
    reset = 1'b0;
    ecnt  = 0;
    set_frame(32'h03030303);
    run(32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
